// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// MULT/MULTU use shift-add on a 2W-bit accumulator, and DIV/DIVU use restoring
// division. Both work on operand magnitudes and apply sign correction at FIX.
// MTHI/MTLO writes are accepted only while idle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWre,
    input  logic             LoWre,
    input  logic [WIDTH-1:0] WriteHiLo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement negate when neg is set (W-bit result path)
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Two's-complement negate when neg is set (2W-bit product path)
    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;   // product sign / quotient sign
    logic                 neg_hi_q, neg_hi_d;   // remainder sign (dividend sign)
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;         // mul: product/multiplier; div: low half dividend->quotient
    logic [WIDTH:0]       rem_q, rem_d;         // partial remainder for division
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 divzero_q, divzero_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift, div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Magnitudes of the incoming operands (signed ops only)
    assign signed_op = ~Op[0];
    assign a_mag     = cond_neg_w(A, signed_op & A[WIDTH-1]);
    assign b_mag     = cond_neg_w(B, signed_op & B[WIDTH-1]);

    // One shift-add step: add the multiplicand to the upper half when the low bit is set
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    // One restoring step: bring in the next dividend bit and try subtracting the divisor
    assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mcand_q};

    // Sign-corrected results; correcting the remainder of a divide-by-zero
    // with the dividend sign gives back the raw dividend
    assign prod_fix  = cond_neg_2w(acc_q, neg_lo_q);
    assign quo_fix   = cond_neg_w(acc_q[WIDTH-1:0], neg_lo_q);
    assign rem_fix   = cond_neg_w(rem_q[WIDTH-1:0], neg_hi_q);

    assign Busy    = (state_q != S_IDLE);
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

    // Next-state logic: FSM sequencing, operand latch, iteration and result write-back
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        div0_d    = div0_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (HiWre) hi_d = WriteHiLo;
                if (LoWre) lo_d = WriteHiLo;
                if (Start) begin
                    state_d  = S_BUSY;
                    count_d  = '0;
                    is_div_d = Op[1];
                    neg_lo_d = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_hi_d = signed_op & Op[1] & A[WIDTH-1];
                    div0_d   = Op[1] & (B == '0);
                    mcand_d  = Op[1] ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (Op[1] ? a_mag : b_mag)};
                    rem_d    = '0;
                end
            end
            S_BUSY: begin
                if (is_div_q) begin
                    if (!div_trial[WIDTH]) begin
                        rem_d              = div_trial;
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d              = div_shift;
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                divzero_d = div0_q;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset clears everything, including HI/LO
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            div0_q    <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            div0_q    <= div0_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner-case
// sequences and randomized operations against a 64-bit arithmetic model.
module tb_mul_div_unit;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [1:0]    Op = 2'd0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          HiWre = 1'b0;
    logic          LoWre = 1'b0;
    logic [W-1:0]  WriteHiLo = '0;
    logic          Busy, Done, DivZero;
    logic [W-1:0]  Hi, Lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWre(HiWre), .LoWre(LoWre), .WriteHiLo(WriteHiLo),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural values
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint      sa, sb, sq, sr;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                t = 64'(sa * sb);
                hi = t[63:32]; lo = t[31:0];
            end
            2'd1: begin
                t = {32'd0, a} * {32'd0, b};
                hi = t[63:32]; lo = t[31:0];
            end
            default: begin
                if (b == '0) begin
                    dz = 1'b1; lo = '1; hi = a;
                end else if (op == 2'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    t = 64'(sq); lo = t[31:0];
                    t = 64'(sr); hi = t[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Launch one op and wait (bounded) for Done. inj >= 0 pulses Start plus
    // HiWre/LoWre with different data inj cycles after launch.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj, output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                          output logic rdz, output logic rbusy, output int lat, output int bcnt,
                          output bit got);
        logic [W-1:0] hi_before;
        logic [W-1:0] lo_before;
        rhi = '0; rlo = '0; rdz = 1'b0; rbusy = 1'b1; got = 1'b0; lat = 0; bcnt = 0;
        @(negedge CLK);
        Op = op; A = a; B = b; Start = 1'b1;
        hi_before = Hi;
        lo_before = Lo;
        @(negedge CLK);
        Start = 1'b0;
        A = $urandom; B = $urandom; Op = 2'($urandom);
        if (Busy) bcnt++;
        while (!got && lat < 100) begin
            if (lat == inj) begin
                Start = 1'b1; HiWre = 1'b1; LoWre = 1'b1; WriteHiLo = 32'hDEADBEEF;
                A = 32'h5; B = 32'h3;
            end
            @(negedge CLK);
            lat++;
            if (lat == inj + 1) begin
                chk("hi_hold_busy", {32'd0, Hi}, {32'd0, hi_before});
                chk("lo_hold_busy", {32'd0, Lo}, {32'd0, lo_before});
            end
            Start = 1'b0; HiWre = 1'b0; LoWre = 1'b0;
            if (Done) begin
                got = 1'b1; rhi = Hi; rlo = Lo; rdz = DivZero; rbusy = Busy;
            end else if (Busy) begin
                bcnt++;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                            input logic edz, input int inj);
        logic [W-1:0] rhi, rlo;
        logic         rdz, rbusy;
        int           lat, bcnt;
        bit           got;
        run_op(op, a, b, inj, rhi, rlo, rdz, rbusy, lat, bcnt, got);
        if (!got) begin
            chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_hi"}, {32'd0, rhi}, {32'd0, ehi});
            chk({tag, "_lo"}, {32'd0, rlo}, {32'd0, elo});
            chk({tag, "_divzero"}, {63'd0, rdz}, {63'd0, edz});
            chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
            chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(W + 1));
            chk({tag, "_busy_at_done"}, {63'd0, rbusy}, 64'd0);
            @(negedge CLK);
            chk({tag, "_done_pulse"}, {62'd0, Done, DivZero}, 64'd0);
        end
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb, ehi, elo;
        logic         edz;
        int           n;

        tbl[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        tbl[4]  = '{2'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[6]  = '{2'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        tbl[7]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[8]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[9]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[10] = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        tbl[11] = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

        // Reset state
        #12;
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_done", {62'd0, Done, DivZero}, 64'd0);
        chk("rst_hilo", {Hi, Lo}, 64'd0);
        @(negedge CLK);
        Reset = 1'b0;

        // MTLO / MTHI in idle
        @(negedge CLK);
        LoWre = 1'b1; WriteHiLo = 32'hA5A5A5A5;
        @(negedge CLK);
        LoWre = 1'b0;
        chk("mtlo", {Hi, Lo}, {32'd0, 32'hA5A5A5A5});
        HiWre = 1'b1; WriteHiLo = 32'h5A5A0001;
        @(negedge CLK);
        HiWre = 1'b0;
        chk("mthi", {Hi, Lo}, {32'h5A5A0001, 32'hA5A5A5A5});

        // Directed table
        for (int i = 0; i < 12; i++) begin
            check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                     tbl[i].hi, tbl[i].lo, tbl[i].dz, -1);
        end

        // Start + MTHI/MTLO pulsed 5 cycles into an op: ignored
        check_op("restart_ignored", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 5);

        // MTHI on the same edge as Start: write lands, result overwrites it at FIX
        @(negedge CLK);
        Op = 2'd1; A = 32'd3; B = 32'd5; Start = 1'b1; HiWre = 1'b1; WriteHiLo = 32'h12345678;
        @(negedge CLK);
        Start = 1'b0; HiWre = 1'b0;
        chk("same_edge_mthi", {32'd0, Hi}, {32'd0, 32'h12345678});
        n = 0;
        while (!Done && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!Done) chk("same_edge_timeout", 64'd0, 64'd1);
        else chk("same_edge_result", {Hi, Lo}, {32'd0, 32'd15});

        // Asynchronous reset 10 cycles into an op
        @(negedge CLK);
        Op = 2'd0; A = 32'h11111111; B = 32'h3; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (10) @(negedge CLK);
        chk("pre_reset_busy", {63'd0, Busy}, 64'd1);
        #2 Reset = 1'b1;
        #1;
        chk("midop_reset_busy", {63'd0, Busy}, 64'd0);
        chk("midop_reset_hilo", {Hi, Lo}, 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (Done || Busy) n++;
        end
        chk("no_done_after_reset", 64'(n), 64'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'($urandom_range(0, 255));
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            model(rop, ra, rb, ehi, elo, edz);
            check_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ehi, elo, edz, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
